sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
// PURPOSE
//  Shares the single external sample memory between the engines that ControlCore
//  launches: record writer, play reader, mix reader and pitch reader.
//  Each engine posts one-word transactions; arbitration is round-robin.
//  The winner's request drives a req/ack memory port. A timeout watchdog
//  keeps a stuck memory from hanging the system. Sits between the engines
//  and the memory controller.
// PARAMETERS
//  N_REQ    4    number of requesters (0=record,1=play,2=mix,3=pitch)
//  ADDR_W   23   word address width (matches chunk select width)
//  DATA_W   16   data word width
//  TIMEOUT  255  max BUSY cycles awaiting i_mem_ack; 0 disables watchdog
// PORTS
//  i_clk        in   1             clock
//  i_rst        in   1             async reset, active-high
//  i_req        in   N_REQ         per-requester request, held until o_ack/o_err
//  i_we         in   N_REQ         1=write, 0=read
//  i_addr       in   N_REQ*ADDR_W  requester k at [k*ADDR_W +: ADDR_W]
//  i_wdata      in   N_REQ*DATA_W  requester k at [k*DATA_W +: DATA_W]
//  o_ack        out  N_REQ         one-cycle completion pulse, one-hot
//  o_err        out  N_REQ         one-cycle timeout pulse, one-hot
//  o_rdata      out  DATA_W        read data, valid while o_ack is high
//  o_busy       out  1             high in BUSY and DONE
//  o_mem_req    out  1             memory request, held until i_mem_ack
//  o_mem_we     out  1             memory write enable
//  o_mem_addr   out  ADDR_W        memory address
//  o_mem_wdata  out  DATA_W        memory write data
//  i_mem_ack    in   1             memory completion, one cycle
//  i_mem_rdata  in   DATA_W        read data, valid with i_mem_ack
// BEHAVIOUR
//  - Reset (async): all outputs 0. State=IDLE, last-grant ptr=N_REQ-1,
//    so requester 0 wins first. Timeout counter=0.
//  - FSM: IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: if any i_req, pick the first requesting index searching ptr+1,
//    ptr+2, ... (mod N_REQ). On that edge, register the winner's we/addr/wdata
//    into o_mem_*, set o_mem_req=1, latch the winner index and go to BUSY.
//    Nothing happens if no request is present.
//  - BUSY: o_mem_* are held stable and the counter increments each cycle.
//    On i_mem_ack: o_mem_req<=0, o_rdata<=i_mem_rdata (reads only; writes keep
//    the previous o_rdata), o_ack[win]<=1, ptr<=win, then go to DONE.
//  - Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT with no ack,
//    o_mem_req<=0, o_err[win]<=1, ptr<=win, then go to DONE. o_rdata is unchanged.
//  - An ack and the timeout in the same cycle count as an ack.
//  - DONE: the o_ack/o_err pulse is visible for exactly one cycle and no
//    arbitration happens. Next state is IDLE, where o_ack/o_err<=0 and the
//    counter is cleared. The requester drops i_req in the cycle after it sees
//    the pulse.
//  - Latency: i_req sampled at cycle 0, o_mem_req high in cycle 1.
//    Ack in cycle k gives o_ack in cycle k+1. Minimum issue spacing: 3 cycles.
//  - If i_req drops during BUSY it is ignored; the transaction still completes
//    and is still acknowledged.
//  - i_mem_ack outside BUSY is ignored.
//  - Reset mid-transaction aborts with no ack; o_mem_req goes to 0 immediately.
// CONFIGURATION
//  SRAM_ARB_PRIO0_EN defined: requester 0 (record) wins whenever it requests,
//    because dropping audio input is unrecoverable. Requesters 1..N_REQ-1 use
//    round-robin among themselves, and ptr updates only on their grants.
//  Not defined: pure round-robin across all N_REQ requesters.
// TESTING
//  1. Read on port 2, addr 0x00_1234, ack 2 cycles after o_mem_req,
//     i_mem_rdata=0xBEEF -> o_mem_addr=0x001234, o_mem_we=0;
//     o_ack=4'b0100 for 1 cycle; o_rdata=0xBEEF.
//  2. Ports 0-3 all requesting after reset, immediate ack -> grant order
//     0,1,2,3,0; each o_ack one-hot; 3-cycle spacing between o_mem_req rises.
//  3. Write on port 1, addr 0x40_0000, wdata 0x1234 -> o_mem_we=1,
//     o_mem_wdata=0x1234; o_ack=4'b0010; o_rdata unchanged.
//  4. TIMEOUT=8, port 3 read, memory never acks -> o_mem_req falls after 8 BUSY
//     cycles; o_err=4'b1000 for 1 cycle; o_ack stays 0. A following port 0
//     request is served normally.
//  5. Reset asserted mid-BUSY -> o_mem_req, o_busy, o_ack all 0 at once.
//     After release, ports 0 and 2 requesting -> port 0 granted first.
//  6. Ports 0 and 3 requesting continuously -> with SRAM_ARB_PRIO0_EN: 0,0,0,...
//     Without it: 0,3,0,3.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter
//   Shares the single external sample memory between the engines started by
//   ControlCore (0=record writer, 1=play reader, 2=mix reader, 3=pitch reader).
//   Each engine posts one-word transactions. A round-robin arbiter picks a
//   winner, whose request is presented on a req/ack memory port. A watchdog
//   ends a transaction with an error pulse if the memory never acknowledges.
//
//   Optional build macro:
//     SRAM_ARB_PRIO0_EN - requester 0 (record) wins whenever it requests.
//                         Requesters 1..N_REQ-1 round-robin among themselves,
//                         and the pointer moves only on their grants.
//     undefined         - pure round-robin over all N_REQ requesters.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_req/i_we         per-requester request (held until o_ack/o_err), 1=write
//   i_addr/i_wdata     packed per-requester address / write data
//   o_ack/o_err        one-cycle one-hot completion / timeout pulses
//   o_rdata            read data, valid while o_ack is high
//   o_busy             high while a transaction is in flight or completing
//   o_mem_*            memory request port, o_mem_req held until i_mem_ack
//   i_mem_ack/rdata    memory completion pulse and read data
// -----------------------------------------------------------------------------
module sram_access_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_we,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_wdata,
  output logic [N_REQ-1:0]          o_ack,
  output logic [N_REQ-1:0]          o_err,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_busy,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic                      i_mem_ack,
  input  logic [DATA_W-1:0]         i_mem_rdata
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

`ifdef SRAM_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [N_REQ-1:0]    err_q, err_d;

  // Unpacked views of the packed per-requester buses.
  logic [ADDR_W-1:0]   addr_arr  [N_REQ];
  logic [DATA_W-1:0]   wdata_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = i_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search ptr+1, ptr+2, ... The loop runs from the farthest
  // candidate to the nearest so the last hit (nearest to ptr+1) wins.
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_vld;
  logic [PTR_W:0]      cand_sum;
  logic [PTR_W-1:0]    cand;

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand_sum >= (PTR_W+1)'(N_REQ)) cand_sum = cand_sum - (PTR_W+1)'(N_REQ);
      cand = cand_sum[PTR_W-1:0];
      if (i_req[cand] && !(PRIO0 && (cand == '0))) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
    // Record input overrides the rotation when it has absolute priority.
    if (PRIO0 && i_req[0]) begin
      grant_idx = '0;
      grant_vld = 1'b1;
    end
  end

  // Watchdog: the counter advances once per BUSY cycle; reaching TIMEOUT ends it.
  logic [CNT_W-1:0]    cnt_inc;
  logic                timeout_hit;
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_BUSY;
      S_BUSY:  if (i_mem_ack || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ack_d       = '0;   // pulses last exactly the DONE cycle
    err_d       = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (grant_vld) begin
          mem_req_d   = 1'b1;
          mem_we_d    = i_we[grant_idx];
          mem_addr_d  = addr_arr[grant_idx];
          mem_wdata_d = wdata_arr[grant_idx];
          win_d       = grant_idx;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        // An ack in the same cycle as the timeout counts as an ack.
        if (i_mem_ack || timeout_hit) begin
          mem_req_d = 1'b0;
          if (!(PRIO0 && (win_q == '0))) ptr_d = win_q;
          if (i_mem_ack) begin
            ack_d[win_q] = 1'b1;
            if (!mem_we_q) rdata_d = i_mem_rdata;
          end else begin
            err_d[win_q] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q       <= PTR_W'(N_REQ - 1);
      win_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
module tb_sram_access_arbiter;

  localparam int N  = 4;
  localparam int AW = 23;
  localparam int DW = 16;
  localparam int TO = 8;

`ifdef SRAM_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      i_req;
  logic [N-1:0]      i_we;
  logic [N*AW-1:0]   i_addr;
  logic [N*DW-1:0]   i_wdata;
  logic [N-1:0]      o_ack;
  logic [N-1:0]      o_err;
  logic [DW-1:0]     o_rdata;
  logic              o_busy;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [AW-1:0]     o_mem_addr;
  logic [DW-1:0]     o_mem_wdata;
  logic              i_mem_ack;
  logic [DW-1:0]     i_mem_rdata;

  sram_access_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ack(o_ack), .o_err(o_err), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: transaction-level view of the arbiter.
  bit            m_active;
  int            m_win;
  int            m_cnt;       // BUSY cycles already completed without ack
  int            m_delay;     // BUSY cycle index at which the memory acks
  logic [N-1:0]  m_ack, m_err;
  int            m_ptr;
  logic [DW-1:0] m_rdata;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            n_txn = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    if (PRIO0 && r[0]) return 0;
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (p + i) % N;
      if (!(PRIO0 && idx == 0) && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_ack = '0;
    m_err = '0;
    m_ptr = N - 1;
    m_rdata = '0;
    m_cnt = 0;
  endtask

  task automatic raise_req(input int k);
    i_req[k] = 1'b1;
    i_we[k] = 1'($urandom_range(0, 1));
    i_addr[k*AW +: AW] = AW'($urandom);
    i_wdata[k*DW +: DW] = DW'($urandom);
  endtask

  task automatic check_outputs();
    check_eq("mem_req", {63'd0, o_mem_req}, {63'd0, m_active});
    check_eq("ack", {60'd0, o_ack}, {60'd0, m_ack});
    check_eq("err", {60'd0, o_err}, {60'd0, m_err});
    check_eq("busy", {63'd0, o_busy}, {63'd0, (m_active || (m_ack != 0) || (m_err != 0))});
    check_eq("rdata", {48'd0, o_rdata}, {48'd0, m_rdata});
    if (m_active) begin
      check_eq("mem_we", {63'd0, o_mem_we}, {63'd0, m_we});
      check_eq("mem_addr", {41'd0, o_mem_addr}, {41'd0, m_addr});
      check_eq("mem_wdata", {48'd0, o_mem_wdata}, {48'd0, m_wdata});
    end
  endtask

  initial begin
    logic [N-1:0]  req_s;
    logic          ack_s;
    logic [DW-1:0] rdata_s;
    int            rst_at [2] = '{600, 1300};
    int            rst_done = 0;

    rst = 1'b1;
    i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_req", {63'd0, o_mem_req}, 64'd0);
    check_eq("rst_busy", {63'd0, o_busy}, 64'd0);
    check_eq("rst_ack", {60'd0, o_ack}, 64'd0);
    check_eq("rst_err", {60'd0, o_err}, 64'd0);
    check_eq("rst_rdata", {48'd0, o_rdata}, 64'd0);
    check_eq("rst_mem_addr", {41'd0, o_mem_addr}, 64'd0);
    rst = 1'b0;
    // All four requesting straight after reset: record must win first.
    for (int k = 0; k < N; k++) raise_req(k);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      #1;
      req_s = i_req;
      ack_s = i_mem_ack;
      rdata_s = i_mem_rdata;

      // Advance the reference by the edge that just happened.
      if (m_active) begin
        m_ack = '0;
        m_err = '0;
        if (ack_s || (m_cnt + 1 == TO)) begin
          m_active = 1'b0;
          if (!(PRIO0 && m_win == 0)) m_ptr = m_win;
          if (ack_s) begin
            m_ack = N'(1 << m_win);
            if (!m_we) m_rdata = rdata_s;
          end else begin
            m_err = N'(1 << m_win);
          end
        end else begin
          m_cnt++;
        end
      end else if ((m_ack != 0) || (m_err != 0)) begin
        m_ack = '0;
        m_err = '0;
      end else if (req_s != 0) begin
        m_win = pick(req_s, m_ptr);
        m_active = 1'b1;
        m_cnt = 0;
        m_delay = $urandom_range(0, 10);
        m_we = i_we[m_win];
        m_addr = i_addr[m_win*AW +: AW];
        m_wdata = i_wdata[m_win*DW +: DW];
      end

      check_outputs();
      if ((m_ack != 0) || (m_err != 0)) begin
        n_txn++;
        $display("txn %0d port=%0d %s we=%0b addr=%06h wdata=%04h rdata=%04h",
                 n_txn, m_win, (m_ack != 0) ? "ack" : "timeout", m_we, m_addr, m_wdata, o_rdata);
      end

      // Memory side: ack on the chosen BUSY cycle, stray acks otherwise.
      if (m_active) i_mem_ack = (m_cnt == m_delay);
      else          i_mem_ack = ($urandom_range(0, 7) == 0);
      i_mem_rdata = DW'($urandom);

      // Requester side.
      for (int k = 0; k < N; k++) begin
        if (m_ack[k] || m_err[k]) i_req[k] = 1'b0;
        else if (m_active && m_win == k) begin
          if (i_req[k] && $urandom_range(0, 15) == 0) i_req[k] = 1'b0;
        end else if (!i_req[k] && $urandom_range(0, 2) == 0) raise_req(k);
      end

      // Reset in the middle of a transaction.
      if (rst_done < 2 && cyc >= rst_at[rst_done] && m_active && m_cnt >= 1) begin
        rst_done++;
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_mem_req", {63'd0, o_mem_req}, 64'd0);
        check_eq("midrst_busy", {63'd0, o_busy}, 64'd0);
        check_eq("midrst_ack", {60'd0, o_ack}, 64'd0);
        check_eq("midrst_err", {60'd0, o_err}, 64'd0);
        i_req = '0;
        i_mem_ack = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_hold_req", {63'd0, o_mem_req}, 64'd0);
        rst = 1'b0;
        model_reset();
        $display("reset applied mid-transaction, ports 0 and 2 requesting");
        raise_req(0);
        raise_req(2);
      end
    end

    check_eq("resets_done", 64'(rst_done), 64'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
